result_accumulator: RTL and testbench

//  Downstream of the systolic core: takes its row-aligned partial-sum rows and

---
 rtl/result_accumulator.sv | 174 +++++++++++++++++
 tb/tb_result_accumulator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_accumulator.sv
// result_accumulator: accumulates systolic partial-sum rows across K-tiles, then drains
// them through ReLU, rounding shift and int8 saturation into the Unified Buffer.
module result_accumulator #(
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int ACC_BW         = 24,
    parameter int DATA_BW        = 8,
    parameter int ACC_DEPTH      = 128,
    parameter int ADDRESSSIZE    = 10
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  cfg_start,
    input  logic [7:0]                            cfg_num_rows,
    input  logic [7:0]                            cfg_num_tiles,
    input  logic [4:0]                            cfg_shift,
    input  logic                                  cfg_relu,
    input  logic [ADDRESSSIZE-1:0]                cfg_ub_base,
    input  logic                                  in_valid,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    output logic                                  in_ready,
    output logic                                  ub_we,
    output logic [ADDRESSSIZE-1:0]                ub_addr,
    output logic [DATA_BW*MATRIX_SIZE-1:0]        ub_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overflow_flag
);
    localparam int AW = $clog2(ACC_DEPTH);
    localparam int EW = ACC_BW + 8;
    localparam logic signed [ACC_BW:0] ACC_MAX = {2'b00, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW:0] ACC_MIN = {2'b11, {(ACC_BW-1){1'b0}}};
    localparam logic signed [EW-1:0]   OUT_MAX = EW'((1 << (DATA_BW-1)) - 1);
    localparam logic signed [EW-1:0]   OUT_MIN = EW'(-(1 << (DATA_BW-1)));

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t                         r_state;
    logic [7:0]                     r_rows, r_tiles, r_row_ptr, r_tile_cnt, r_dptr;
    logic [4:0]                     r_shift;
    logic                           r_relu;
    logic [ADDRESSSIZE-1:0]         r_base;
    logic                           r_in_ready, r_ub_we, r_busy, r_done, r_overflow;
    logic [ADDRESSSIZE-1:0]         r_ub_addr;
    logic [DATA_BW*MATRIX_SIZE-1:0] r_ub_data;
    logic signed [ACC_BW-1:0]       r_acc [ACC_DEPTH][MATRIX_SIZE];

    logic                           w_accept, w_sat_any;
    logic [7:0]                     w_rows_clamped;
    logic signed [ACC_BW:0]         w_in [MATRIX_SIZE];
    logic signed [ACC_BW:0]         w_sum [MATRIX_SIZE];
    logic signed [ACC_BW-1:0]       w_new [MATRIX_SIZE];
    logic signed [EW-1:0]           w_ext [MATRIX_SIZE];
    logic signed [EW-1:0]           w_v [MATRIX_SIZE];
    logic signed [EW-1:0]           w_rnd [MATRIX_SIZE];
    logic [DATA_BW*MATRIX_SIZE-1:0] w_row_out;

    assign in_ready      = r_in_ready;
    assign ub_we         = r_ub_we;
    assign ub_addr       = r_ub_addr;
    assign ub_data       = r_ub_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overflow_flag = r_overflow;

    assign w_accept       = r_in_ready & in_valid;
    assign w_rows_clamped = (cfg_num_rows > 8'(ACC_DEPTH)) ? 8'(ACC_DEPTH) : cfg_num_rows;

    // Rounding is done in a widened lane so the half-LSB add can never wrap, whatever the shift.
    always_comb begin
        w_sat_any = 1'b0;
        w_row_out = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            w_in[i]  = (ACC_BW+1)'($signed(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]));
            w_sum[i] = (ACC_BW+1)'(r_acc[r_row_ptr[AW-1:0]][i]) + w_in[i];
            w_new[i] = (r_tile_cnt == 8'd0) ? w_in[i][ACC_BW-1:0] :
                       (w_sum[i] > ACC_MAX) ? ACC_MAX[ACC_BW-1:0] :
                       (w_sum[i] < ACC_MIN) ? ACC_MIN[ACC_BW-1:0] : w_sum[i][ACC_BW-1:0];
            w_sat_any = w_sat_any | ((r_tile_cnt != 8'd0) && (w_sum[i] > ACC_MAX || w_sum[i] < ACC_MIN));
            w_ext[i] = EW'(r_acc[r_dptr[AW-1:0]][i]);
            w_v[i]   = (r_relu && w_ext[i] < 0) ? '0 : w_ext[i];
            w_rnd[i] = (r_shift == 5'd0) ? w_v[i] :
                       (w_v[i] + $signed(EW'(1) << (r_shift - 5'd1))) >>> r_shift;
            w_row_out[i*DATA_BW +: DATA_BW] = (w_rnd[i] > OUT_MAX) ? OUT_MAX[DATA_BW-1:0] :
                                              (w_rnd[i] < OUT_MIN) ? OUT_MIN[DATA_BW-1:0] :
                                              w_rnd[i][DATA_BW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < MATRIX_SIZE; i++) r_acc[r_row_ptr[AW-1:0]][i] <= w_new[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_rows     <= '0;
            r_tiles    <= '0;
            r_row_ptr  <= '0;
            r_tile_cnt <= '0;
            r_dptr     <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_base     <= '0;
            r_in_ready <= 1'b0;
            r_ub_we    <= 1'b0;
            r_ub_addr  <= '0;
            r_ub_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_rows     <= w_rows_clamped;
                        r_tiles    <= cfg_num_tiles;
                        r_shift    <= cfg_shift;
                        r_relu     <= cfg_relu;
                        r_base     <= cfg_ub_base;
                        r_row_ptr  <= '0;
                        r_tile_cnt <= '0;
                        r_dptr     <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_rows_clamped == 8'd0 || cfg_num_tiles == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (w_sat_any) r_overflow <= 1'b1;
                        if (r_row_ptr == r_rows - 8'd1) begin
                            r_row_ptr  <= '0;
                            r_tile_cnt <= r_tile_cnt + 8'd1;
                            if (r_tile_cnt == r_tiles - 8'd1) begin
                                r_state    <= S_DRAIN;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_row_ptr <= r_row_ptr + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_dptr == r_rows) begin
                        r_ub_we   <= 1'b0;
                        r_ub_addr <= '0;
                        r_ub_data <= '0;
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                    end else begin
                        r_ub_we   <= 1'b1;
                        r_ub_addr <= r_base + ADDRESSSIZE'(r_dptr);
                        r_ub_data <= w_row_out;
                        r_dptr    <= r_dptr + 8'd1;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: directed scenario tasks for result_accumulator with hand-computed results.
module tb_result_accumulator;
    logic         clk = 1'b0, rstn = 1'b0, cfg_start = 1'b0, cfg_relu = 1'b0, in_valid = 1'b0;
    logic [7:0]   cfg_num_rows = '0, cfg_num_tiles = '0;
    logic [4:0]   cfg_shift = '0;
    logic [9:0]   cfg_ub_base = '0;
    logic [159:0] in_data = '0;
    logic         in_ready, ub_we, busy, done, overflow_flag;
    logic [9:0]   ub_addr;
    logic [63:0]  ub_data;

    int total = 0, bad = 0;
    int cyc = 0, n_acc, acc_at_first, last_we, done_cyc, start_cyc, n_done, drain_rdy;
    logic [9:0]  aq[$];
    logic [63:0] dq[$];

    result_accumulator dut (
        .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_num_rows(cfg_num_rows),
        .cfg_num_tiles(cfg_num_tiles), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .cfg_ub_base(cfg_ub_base), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ub_we(ub_we), .ub_addr(ub_addr), .ub_data(ub_data), .busy(busy), .done(done),
        .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) n_acc++;
        if (ub_we) begin
            if (aq.size() == 0) acc_at_first = n_acc;
            aq.push_back(ub_addr);
            dq.push_back(ub_data);
            last_we = cyc;
            if (in_ready) drain_rdy++;
        end
        if (done) begin
            done_cyc = cyc;
            n_done++;
        end
        if (cfg_start && !busy) start_cyc = cyc;
    end

    function automatic logic [159:0] fill(input int v);
        logic [159:0] r;
        for (int i = 0; i < 8; i++) r[i*20 +: 20] = 20'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        aq.delete();
        dq.delete();
        n_acc = 0; acc_at_first = -1; last_we = -1; done_cyc = -1;
        start_cyc = -1; n_done = 0; drain_rdy = 0;
    endtask

    task automatic start_job(input logic [7:0] rows, input logic [7:0] tiles, input logic [4:0] sh,
                             input logic relu, input logic [9:0] base);
        cfg_num_rows = rows; cfg_num_tiles = tiles; cfg_shift = sh; cfg_relu = relu; cfg_ub_base = base;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_row(input logic [159:0] d, input int gap, output bit ok);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = d;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = done;
        end
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) tick();
        total++;
        if ({in_ready, ub_we, busy, done, overflow_flag} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000", {in_ready, ub_we, busy, done, overflow_flag});
        end
        total++;
        if (ub_addr !== 10'd0 || ub_data !== 64'd0) begin
            bad++; $display("FAIL reset_bus got addr=%h data=%h exp 0", ub_addr, ub_data);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int nok = 0;
        clear_mon();
        start_job(8'd2, 8'd1, 5'd0, 1'b0, 10'h010);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL t1_start got busy=%b rdy=%b exp 1 1", busy, in_ready);
        end
        for (int r = 0; r < 2; r++) begin send_row(fill(5), 0, ok); nok += int'(!ok); end
        wait_done(ok);
        total++;
        if (!ok || nok != 0) begin bad++; $display("FAIL t1_flow got done=%b rejects=%0d exp 1 0", ok, nok); end
        total++;
        if (aq.size() != 2) begin bad++; $display("FAIL t1_nwr got=%0d exp=2", aq.size()); end
        for (int r = 0; r < aq.size(); r++) begin
            total++;
            if (aq[r] !== 10'(16 + r) || dq[r] !== {8{8'h05}}) begin
                bad++; $display("FAIL t1_row%0d got %h:%h exp %h:%h", r, aq[r], dq[r], 10'(16 + r), {8{8'h05}});
            end
        end
        total++;
        if (done_cyc != last_we + 1) begin
            bad++; $display("FAIL t1_done_lat got=%0d exp=%0d", done_cyc, last_we + 1);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_tiles();
        bit ok;
        int nok = 0;
        clear_mon();
        start_job(8'd2, 8'd3, 5'd2, 1'b0, 10'h020);
        for (int r = 0; r < 6; r++) begin send_row(fill(100), 0, ok); nok += int'(!ok); end
        wait_done(ok);
        total++;
        if (!ok || nok != 0) begin bad++; $display("FAIL t2_flow got done=%b rejects=%0d exp 1 0", ok, nok); end
        total++;
        if (aq.size() != 2) begin bad++; $display("FAIL t2_nwr got=%0d exp=2", aq.size()); end
        for (int r = 0; r < aq.size(); r++) begin
            total++;
            if (dq[r] !== {8{8'h4B}}) begin bad++; $display("FAIL t2_data%0d got=%h exp=%h", r, dq[r], {8{8'h4B}}); end
        end
        total++;
        if (acc_at_first != 6) begin bad++; $display("FAIL t2_acc_before_we got=%0d exp=6", acc_at_first); end
        total++;
        if (overflow_flag !== 1'b0) begin bad++; $display("FAIL t2_ovf got=%b exp=0", overflow_flag); end
    endtask

    task automatic test_relu();
        bit ok;
        logic [159:0] d;
        logic [63:0] exp_d [2];
        exp_d[0] = 64'h00000000_807FCECE;
        exp_d[1] = 64'h00000000_007F0000;
        d = fill(0);
        d[19:0] = 20'(-50); d[39:20] = 20'(-50); d[59:40] = 20'(1000); d[79:60] = 20'(-1000);
        for (int m = 0; m < 2; m++) begin
            clear_mon();
            start_job(8'd1, 8'd1, 5'd0, 1'(m), 10'h100);
            send_row(d, 1, ok);
            wait_done(ok);
            total++;
            if (dq.size() != 1 || dq[0] !== exp_d[m]) begin
                bad++; $display("FAIL t3_relu%0d got n=%0d data=%h exp n=1 data=%h", m, dq.size(),
                                dq.size() > 0 ? dq[0] : 64'd0, exp_d[m]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int nok = 0;
        clear_mon();
        start_job(8'd1, 8'd17, 5'd16, 1'b0, 10'h200);
        for (int t = 0; t < 17; t++) begin send_row(fill(524287), 0, ok); nok += int'(!ok); end
        wait_done(ok);
        total++;
        if (!ok || nok != 0) begin bad++; $display("FAIL t4_flow got done=%b rejects=%0d exp 1 0", ok, nok); end
        total++;
        if (dq.size() != 1 || dq[0] !== {8{8'h7F}}) begin
            bad++; $display("FAIL t4_data got n=%0d data=%h exp n=1 data=%h", dq.size(),
                            dq.size() > 0 ? dq[0] : 64'd0, {8{8'h7F}});
        end
        total++;
        if (overflow_flag !== 1'b1) begin bad++; $display("FAIL t4_ovf got=%b exp=1", overflow_flag); end
    endtask

    task automatic test_wrap();
        bit ok;
        int nok = 0;
        logic [9:0] ea;
        clear_mon();
        start_job(8'd4, 8'd1, 5'd0, 1'b0, 10'd1022);
        total++;
        if (overflow_flag !== 1'b0) begin bad++; $display("FAIL t5_ovf_clear got=%b exp=0", overflow_flag); end
        send_row(fill(1), int'($urandom_range(0, 3)), ok); nok += int'(!ok);
        cfg_num_rows = 8'd1; cfg_ub_base = 10'd0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int r = 1; r < 4; r++) begin send_row(fill(r + 1), int'($urandom_range(0, 3)), ok); nok += int'(!ok); end
        wait_done(ok);
        total++;
        if (!ok || nok != 0) begin bad++; $display("FAIL t5_flow got done=%b rejects=%0d exp 1 0", ok, nok); end
        total++;
        if (aq.size() != 4) begin bad++; $display("FAIL t5_nwr got=%0d exp=4", aq.size()); end
        for (int r = 0; r < aq.size(); r++) begin
            ea = 10'(1022 + r);
            total++;
            if (aq[r] !== ea || dq[r] !== {8{8'(r + 1)}}) begin
                bad++; $display("FAIL t5_row%0d got %0d:%h exp %0d:%h", r, aq[r], dq[r], ea, {8{8'(r + 1)}});
            end
        end
        total++;
        if (drain_rdy != 0) begin bad++; $display("FAIL t5_rdy_in_drain got=%0d exp=0", drain_rdy); end
        repeat (5) tick();
        total++;
        if (n_done != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL t5_single_job got dones=%0d busy=%b exp 1 0", n_done, busy);
        end
    endtask

    task automatic test_reset_midjob();
        bit ok;
        int nok = 0;
        clear_mon();
        start_job(8'd2, 8'd2, 5'd0, 1'b0, 10'h040);
        send_row(fill(1000), 0, ok);
        rstn = 1'b0;
        tick();
        total++;
        if ({in_ready, ub_we, busy, done, overflow_flag} !== 5'b0 || ub_addr !== 10'd0 || ub_data !== 64'd0) begin
            bad++; $display("FAIL t6_abort got ctrl=%b addr=%h data=%h exp 0", {in_ready, ub_we, busy, done, overflow_flag}, ub_addr, ub_data);
        end
        rstn = 1'b1;
        repeat (3) tick();
        total++;
        if (n_done != 0 || aq.size() != 0) begin
            bad++; $display("FAIL t6_no_done got dones=%0d writes=%0d exp 0 0", n_done, aq.size());
        end
        clear_mon();
        start_job(8'd2, 8'd1, 5'd0, 1'b0, 10'h040);
        for (int r = 0; r < 2; r++) begin send_row(fill(3), 0, ok); nok += int'(!ok); end
        wait_done(ok);
        total++;
        if (!ok || nok != 0 || aq.size() != 2) begin
            bad++; $display("FAIL t6_fresh got done=%b rejects=%0d writes=%0d exp 1 0 2", ok, nok, aq.size());
        end
        for (int r = 0; r < aq.size(); r++) begin
            total++;
            if (aq[r] !== 10'(64 + r) || dq[r] !== {8{8'h03}}) begin
                bad++; $display("FAIL t6_row%0d got %h:%h exp %h:%h", r, aq[r], dq[r], 10'(64 + r), {8{8'h03}});
            end
        end
    endtask

    task automatic test_zero_and_clamp();
        bit ok;
        int nok = 0;
        for (int m = 0; m < 2; m++) begin
            clear_mon();
            start_job(m == 0 ? 8'd0 : 8'd3, m == 0 ? 8'd5 : 8'd0, 5'd0, 1'b0, 10'h000);
            wait_done(ok);
            total++;
            if (!ok || aq.size() != 0 || done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
                bad++; $display("FAIL zero_job%0d got done=%b writes=%0d lat=%0d exp 1 0 1..2", m, ok, aq.size(), done_cyc - start_cyc);
            end
        end
        clear_mon();
        start_job(8'd200, 8'd1, 5'd0, 1'b0, 10'h000);
        for (int r = 0; r < 128; r++) begin send_row(fill(1), 0, ok); nok += int'(!ok); end
        wait_done(ok);
        total++;
        if (!ok || nok != 0 || aq.size() != 128) begin
            bad++; $display("FAIL clamp got done=%b rejects=%0d writes=%0d exp 1 0 128", ok, nok, aq.size());
        end
        total++;
        if (aq.size() == 0 || aq[aq.size() - 1] !== 10'd127) begin
            bad++; $display("FAIL clamp_last_addr got=%0d exp=127", aq.size() > 0 ? aq[aq.size() - 1] : 10'd0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tiles();
        test_relu();
        test_overflow();
        test_wrap();
        test_reset_midjob();
        test_zero_and_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
